// File: rtl/ysyx_23060072_id2ex_reg.sv
// ID->EX pipeline register for the rv32e core. It detects load-use hazards,
// inserts one bubble per hazard, and drops its contents on a branch redirect.
module ysyx_23060072_id2ex_reg #(
  parameter int STORE_DATA_FWD = 0,
  parameter int ALU_OP_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [31:0]         id_pc,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic                id_has_rs1,
  input  logic                id_has_rs2,
  input  logic [4:0]          id_wb_addr,
  input  logic                id_wb_flag,
  input  logic                id_load_flag,
  input  logic                id_store_flag,
  input  logic [31:0]         id_operand_a,
  input  logic [31:0]         id_operand_b,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                ex_ready,
  output logic                id2ex_valid,
  output logic [31:0]         id2ex_pc,
  output logic [4:0]          id2ex_rs1_addr,
  output logic [4:0]          id2ex_rs2_addr,
  output logic                id2ex_has_rs1,
  output logic                id2ex_has_rs2,
  output logic [4:0]          id2ex_wb_addr,
  output logic                id2ex_wb_flag,
  output logic                id2ex_load_flag,
  output logic                id2ex_store_flag,
  output logic [31:0]         id2ex_operand_a,
  output logic [31:0]         id2ex_operand_b,
  output logic [ALU_OP_W-1:0] id2ex_alu_op,
  output logic [31:0]         load_use_stalls
);

  logic adv;
  logic hz;
  logic fire_in;
  logic rs1_match;
  logic rs2_match;
  logic store_fwd;

  assign store_fwd = (STORE_DATA_FWD != 0);

  // A hazard exists only while the producing load is still in this register;
  // once it moves to EX the LSU->EX forward path covers the consumer.
  always_comb begin
    adv       = !id2ex_valid || ex_ready;
    rs1_match = id_has_rs1 && (id_rs1_addr == id2ex_wb_addr);
    rs2_match = id_has_rs2 && (id_rs2_addr == id2ex_wb_addr) && !(store_fwd && id_store_flag);
    hz        = id2ex_valid && id2ex_load_flag && id2ex_wb_flag && (id2ex_wb_addr != 5'd0) &&
                id_valid && (rs1_match || rs2_match);
    id_ready  = adv && !hz && !flush;
    fire_in   = id_valid && id_ready;
  end

  // Valid and all flags are cleared on flush or bubble so forwarding never matches a dead slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id2ex_valid      <= 1'b0;
      id2ex_has_rs1    <= 1'b0;
      id2ex_has_rs2    <= 1'b0;
      id2ex_wb_flag    <= 1'b0;
      id2ex_load_flag  <= 1'b0;
      id2ex_store_flag <= 1'b0;
    end else if (flush || (adv && !fire_in)) begin
      id2ex_valid      <= 1'b0;
      id2ex_has_rs1    <= 1'b0;
      id2ex_has_rs2    <= 1'b0;
      id2ex_wb_flag    <= 1'b0;
      id2ex_load_flag  <= 1'b0;
      id2ex_store_flag <= 1'b0;
    end else if (fire_in) begin
      id2ex_valid      <= 1'b1;
      id2ex_has_rs1    <= id_has_rs1;
      id2ex_has_rs2    <= id_has_rs2;
      id2ex_wb_flag    <= id_wb_flag;
      id2ex_load_flag  <= id_load_flag;
      id2ex_store_flag <= id_store_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id2ex_pc        <= 32'd0;
      id2ex_rs1_addr  <= 5'd0;
      id2ex_rs2_addr  <= 5'd0;
      id2ex_wb_addr   <= 5'd0;
      id2ex_operand_a <= 32'd0;
      id2ex_operand_b <= 32'd0;
      id2ex_alu_op    <= '0;
    end else if (fire_in) begin
      id2ex_pc        <= id_pc;
      id2ex_rs1_addr  <= id_rs1_addr;
      id2ex_rs2_addr  <= id_rs2_addr;
      id2ex_wb_addr   <= id_wb_addr;
      id2ex_operand_a <= id_operand_a;
      id2ex_operand_b <= id_operand_b;
      id2ex_alu_op    <= id_alu_op;
    end
  end

  // Counts only bubbles actually inserted; a flush in the same cycle cancels the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_stalls <= 32'd0;
    end else if (hz && adv && !flush && (load_use_stalls != 32'hFFFF_FFFF)) begin
      load_use_stalls <= load_use_stalls + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_id2ex_reg.sv
// Directed bench for the ID->EX register: a queue of expected instructions is
// drained by a monitor whenever EX consumes a valid entry.
module tb_ysyx_23060072_id2ex_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        has1;
    logic        has2;
    logic [4:0]  wb;
    logic        wbf;
    logic        ld;
    logic        st;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  op;
  } instr_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_has_rs1;
  logic        id_has_rs2;
  logic [4:0]  id_wb_addr;
  logic        id_wb_flag;
  logic        id_load_flag;
  logic        id_store_flag;
  logic [31:0] id_operand_a;
  logic [31:0] id_operand_b;
  logic [3:0]  id_alu_op;
  logic        ex_ready;
  logic        id2ex_valid;
  logic [31:0] id2ex_pc;
  logic [4:0]  id2ex_rs1_addr;
  logic [4:0]  id2ex_rs2_addr;
  logic        id2ex_has_rs1;
  logic        id2ex_has_rs2;
  logic [4:0]  id2ex_wb_addr;
  logic        id2ex_wb_flag;
  logic        id2ex_load_flag;
  logic        id2ex_store_flag;
  logic [31:0] id2ex_operand_a;
  logic [31:0] id2ex_operand_b;
  logic [3:0]  id2ex_alu_op;
  logic [31:0] load_use_stalls;

  logic        f_id_ready;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [4:0]  f_rs1_addr;
  logic [4:0]  f_rs2_addr;
  logic        f_has_rs1;
  logic        f_has_rs2;
  logic [4:0]  f_wb_addr;
  logic        f_wb_flag;
  logic        f_load_flag;
  logic        f_store_flag;
  logic [31:0] f_operand_a;
  logic [31:0] f_operand_b;
  logic [3:0]  f_alu_op;
  logic [31:0] f_stalls;

  int     checks;
  int     failures;
  instr_t sb[$];

  ysyx_23060072_id2ex_reg #(.STORE_DATA_FWD(0), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_has_rs1(id_has_rs1), .id_has_rs2(id_has_rs2), .id_wb_addr(id_wb_addr),
    .id_wb_flag(id_wb_flag), .id_load_flag(id_load_flag), .id_store_flag(id_store_flag),
    .id_operand_a(id_operand_a), .id_operand_b(id_operand_b), .id_alu_op(id_alu_op),
    .ex_ready(ex_ready), .id2ex_valid(id2ex_valid), .id2ex_pc(id2ex_pc),
    .id2ex_rs1_addr(id2ex_rs1_addr), .id2ex_rs2_addr(id2ex_rs2_addr),
    .id2ex_has_rs1(id2ex_has_rs1), .id2ex_has_rs2(id2ex_has_rs2),
    .id2ex_wb_addr(id2ex_wb_addr), .id2ex_wb_flag(id2ex_wb_flag),
    .id2ex_load_flag(id2ex_load_flag), .id2ex_store_flag(id2ex_store_flag),
    .id2ex_operand_a(id2ex_operand_a), .id2ex_operand_b(id2ex_operand_b),
    .id2ex_alu_op(id2ex_alu_op), .load_use_stalls(load_use_stalls)
  );

  ysyx_23060072_id2ex_reg #(.STORE_DATA_FWD(1), .ALU_OP_W(4)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(f_id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_has_rs1(id_has_rs1), .id_has_rs2(id_has_rs2), .id_wb_addr(id_wb_addr),
    .id_wb_flag(id_wb_flag), .id_load_flag(id_load_flag), .id_store_flag(id_store_flag),
    .id_operand_a(id_operand_a), .id_operand_b(id_operand_b), .id_alu_op(id_alu_op),
    .ex_ready(ex_ready), .id2ex_valid(f_valid), .id2ex_pc(f_pc),
    .id2ex_rs1_addr(f_rs1_addr), .id2ex_rs2_addr(f_rs2_addr),
    .id2ex_has_rs1(f_has_rs1), .id2ex_has_rs2(f_has_rs2),
    .id2ex_wb_addr(f_wb_addr), .id2ex_wb_flag(f_wb_flag),
    .id2ex_load_flag(f_load_flag), .id2ex_store_flag(f_store_flag),
    .id2ex_operand_a(f_operand_a), .id2ex_operand_b(f_operand_b),
    .id2ex_alu_op(f_alu_op), .load_use_stalls(f_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic has1, input logic has2, input logic [4:0] wb,
                                input logic wbf, input logic ld, input logic st,
                                input logic [31:0] opa, input logic [31:0] opb, input logic [3:0] op);
    instr_t r;
    r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.has1 = has1; r.has2 = has2; r.wb = wb;
    r.wbf = wbf; r.ld = ld; r.st = st; r.opa = opa; r.opb = opb; r.op = op;
    return r;
  endfunction

  task automatic applyStimulus(input instr_t ins, input logic valid);
    id_valid      = valid;
    id_pc         = ins.pc;
    id_rs1_addr   = ins.rs1;
    id_rs2_addr   = ins.rs2;
    id_has_rs1    = ins.has1;
    id_has_rs2    = ins.has2;
    id_wb_addr    = ins.wb;
    id_wb_flag    = ins.wbf;
    id_load_flag  = ins.ld;
    id_store_flag = ins.st;
    id_operand_a  = ins.opa;
    id_operand_b  = ins.opb;
    id_alu_op     = ins.op;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle EX takes a valid entry, it must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst_n && id2ex_valid && ex_ready) begin
      instr_t act;
      instr_t exp;
      act = mk(id2ex_pc, id2ex_rs1_addr, id2ex_rs2_addr, id2ex_has_rs1, id2ex_has_rs2,
               id2ex_wb_addr, id2ex_wb_flag, id2ex_load_flag, id2ex_store_flag,
               id2ex_operand_a, id2ex_operand_b, id2ex_alu_op);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_underflow: got pc %h expected no transfer", act.pc);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          failures++;
          $display("[TB] FAIL sb_entry: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    instr_t nop, a0, lw5, add_dep, lw5b, sw5, lw0, add_x0, lw5c, addi, ix, iy, lw5d, add_f;
    checks   = 0;
    failures = 0;
    nop     = mk(32'h0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    a0      = mk(32'h100, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 32'h11, 32'h22, 4'h1);
    lw5     = mk(32'h200, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 32'h1000, 32'h4, 4'h0);
    add_dep = mk(32'h204, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 32'hA, 32'hB, 4'h1);
    lw5b    = mk(32'h300, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 32'h2000, 32'h8, 4'h0);
    sw5     = mk(32'h304, 5'd8, 5'd5, 1, 1, 5'd0, 0, 0, 1, 32'h3000, 32'h0, 4'h0);
    lw0     = mk(32'h400, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 32'h44, 32'h0, 4'h0);
    add_x0  = mk(32'h404, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 32'h0, 32'h0, 4'h1);
    lw5c    = mk(32'h408, 5'd3, 5'd0, 1, 0, 5'd5, 1, 1, 0, 32'h48, 32'h0, 4'h0);
    addi    = mk(32'h40C, 5'd9, 5'd5, 1, 0, 5'd6, 1, 0, 0, 32'h99, 32'h1, 4'h2);
    ix      = mk(32'h500, 5'd4, 5'd6, 1, 1, 5'd7, 1, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'h3);
    iy      = mk(32'h504, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 4'h4);
    lw5d    = mk(32'h600, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 32'h60, 32'h0, 4'h0);
    add_f   = mk(32'h604, 5'd5, 5'd5, 1, 1, 5'd9, 1, 0, 0, 32'h61, 32'h62, 4'h1);

    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    applyStimulus(nop, 1'b0);
    #12;
    checkOutput("reset_valid", {31'd0, id2ex_valid}, 32'd0);
    checkOutput("reset_stalls", load_use_stalls, 32'd0);
    step();
    rst_n = 1'b1;

    // Reset mid-stream with a valid entry held.
    applyStimulus(a0, 1'b1);
    #1;
    checkOutput("t1_id_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(a0);
    step();
    ex_ready = 1'b0;
    applyStimulus(nop, 1'b0);
    checkOutput("t1_valid_before_rst", {31'd0, id2ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_valid", {31'd0, id2ex_valid}, 32'd0);
    checkOutput("t1_async_pc", id2ex_pc, 32'd0);
    checkOutput("t1_async_opa", id2ex_operand_a, 32'd0);
    checkOutput("t1_async_wbf", {31'd0, id2ex_wb_flag}, 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    #1;
    checkOutput("t1_ready_after_rst", {31'd0, id_ready}, 32'd1);

    // Load-use on rs1: one bubble.
    applyStimulus(lw5, 1'b1);
    #1;
    checkOutput("t2_lw_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(lw5);
    step();
    applyStimulus(add_dep, 1'b1);
    #1;
    checkOutput("t2_stall_ready", {31'd0, id_ready}, 32'd0);
    step();
    checkOutput("t2_bubble_valid", {31'd0, id2ex_valid}, 32'd0);
    checkOutput("t2_bubble_flags", {27'd0, id2ex_wb_flag, id2ex_load_flag, id2ex_store_flag,
                                    id2ex_has_rs1, id2ex_has_rs2}, 32'd0);
    checkOutput("t2_stalls", load_use_stalls, 32'd1);
    checkOutput("t2_ready_after", {31'd0, id_ready}, 32'd1);
    sb.push_back(add_dep);
    step();
    checkOutput("t2_add_pc", id2ex_pc, 32'h204);
    applyStimulus(nop, 1'b0);
    step();

    // Store whose data register alone matches the load.
    applyStimulus(lw5b, 1'b1);
    sb.push_back(lw5b);
    step();
    applyStimulus(sw5, 1'b1);
    #1;
    checkOutput("t3_ready_nofwd", {31'd0, id_ready}, 32'd0);
    checkOutput("t3_ready_fwd", {31'd0, f_id_ready}, 32'd1);
    step();
    checkOutput("t3_bubble_valid", {31'd0, id2ex_valid}, 32'd0);
    checkOutput("t3_stalls_nofwd", load_use_stalls, 32'd2);
    checkOutput("t3_stalls_fwd", f_stalls, 32'd1);
    checkOutput("t3_fwd_store_in", {30'd0, f_valid, f_store_flag}, 32'd3);
    checkOutput("t3_ready_after", {31'd0, id_ready}, 32'd1);
    sb.push_back(sw5);
    step();
    checkOutput("t3_sw_pc", id2ex_pc, 32'h304);
    checkOutput("t3_stalls_fwd_end", f_stalls, 32'd1);
    applyStimulus(nop, 1'b0);
    step();

    // x0 destination and non-matching sources never stall.
    applyStimulus(lw0, 1'b1);
    sb.push_back(lw0);
    step();
    applyStimulus(add_x0, 1'b1);
    #1;
    checkOutput("t4_x0_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(add_x0);
    step();
    applyStimulus(lw5c, 1'b1);
    sb.push_back(lw5c);
    step();
    applyStimulus(addi, 1'b1);
    #1;
    checkOutput("t4_nomatch_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(addi);
    step();
    checkOutput("t4_stalls", load_use_stalls, 32'd2);
    applyStimulus(nop, 1'b0);
    step();

    // EX back-pressure holds the register stable.
    applyStimulus(ix, 1'b1);
    sb.push_back(ix);
    step();
    ex_ready = 1'b0;
    applyStimulus(iy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t5_hold_ready", {31'd0, id_ready}, 32'd0);
      checkOutput("t5_hold_pc", id2ex_pc, 32'h500);
      checkOutput("t5_hold_opb", id2ex_operand_b, 32'hCAFE_F00D);
      step();
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("t5_release_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(iy);
    step();
    checkOutput("t5_next_pc", id2ex_pc, 32'h504);
    applyStimulus(nop, 1'b0);
    step();

    // Flush together with a hazard: flush wins, no count.
    applyStimulus(lw5d, 1'b1);
    sb.push_back(lw5d);
    step();
    applyStimulus(add_f, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("t6_flush_ready", {31'd0, id_ready}, 32'd0);
    step();
    flush = 1'b0;
    checkOutput("t6_flush_valid", {31'd0, id2ex_valid}, 32'd0);
    checkOutput("t6_flush_load", {31'd0, id2ex_load_flag}, 32'd0);
    checkOutput("t6_stalls", load_use_stalls, 32'd2);
    #1;
    checkOutput("t6_ready_after", {31'd0, id_ready}, 32'd1);
    sb.push_back(add_f);
    step();
    checkOutput("t6_add_pc", id2ex_pc, 32'h604);
    applyStimulus(nop, 1'b0);
    step();
    step();
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
